frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
- Generates the quarter-frame and half-frame clock pulses that drive the envelope, length-counter and sweep units of every pulse channel.
- Sits directly upstream of the pulse channels: its outputs connect to their qtr_clk/hlf_clk inputs.
- Models the APU frame counter: 4-step and 5-step modes, driven by CPU writes to the frame-counter register.
- Also produces the frame interrupt flag.

Parameters:
STEP1, 3728, APU-cycle count of the first quarter-frame event
STEP2, 7456, count of the second event (quarter + half)
STEP3, 11185, count of the third event (quarter)
STEP4, 14914, count of the fourth event; last step in 4-step mode
STEP5, 18640, count of the last step in 5-step mode
CNT_W, 15, counter width; must hold STEP5

Ports:
apu_clk  input  1  APU cycle clock; one edge = one APU cycle
rst  input  1  synchronous active-high reset
reg_wr  input  1  single-cycle write strobe for the frame-counter register
reg_data  input  8  write data; bit7 = mode (0 = 4-step, 1 = 5-step), bit6 = IRQ inhibit
irq_ack  input  1  single-cycle frame IRQ acknowledge (status read)
qtr_clk  output  1  registered one-cycle pulse at each quarter-frame event
hlf_clk  output  1  registered one-cycle pulse at each half-frame event
frame_irq  output  1  frame interrupt flag, level

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high.
- Reset (rst high at apu_clk edge):
  - counter = 0, mode = 0, inhibit = 0.
  - qtr_clk = 0, hlf_clk = 0, frame_irq = 0.
  - rst overrides every other input.
- Counter:
  - Increments by 1 each cycle.
  - 4-step mode: wraps to 0 on the cycle after count == STEP4; period = STEP4+1 cycles.
  - 5-step mode: wraps to 0 on the cycle after count == STEP5; period = STEP5+1 cycles.
- Event decode is combinational on the current count; pulses are registered and appear the cycle after the match.
  - 4-step mode:
    - STEP1: qtr.
    - STEP2: qtr + hlf.
    - STEP3: qtr.
    - STEP4: qtr + hlf; frame_irq set if inhibit = 0.
  - 5-step mode:
    - STEP1: qtr.
    - STEP2: qtr + hlf.
    - STEP3: qtr.
    - STEP4: no event, no IRQ.
    - STEP5: qtr + hlf.
- Pulse width: qtr_clk and hlf_clk are high for exactly one cycle per event. Consecutive events are never adjacent.
- Register write (reg_wr = 1):
  - Latch mode = reg_data[7] and inhibit = reg_data[6].
  - Counter loads 0.
  - If reg_data[6] = 1, frame_irq clears the same edge.
  - If reg_data[7] = 1, qtr_clk and hlf_clk both pulse on the next cycle (immediate clock).
  - If reg_data[7] = 0, no immediate pulse.
- Simultaneous events:
  - Write on the same cycle as a step match: the write wins and the step's pulses/IRQ are suppressed. The mode-1 immediate pulse still occurs.
  - irq_ack on the same cycle as the IRQ set condition: set wins, frame_irq stays 1.
  - irq_ack with no set condition: frame_irq clears next edge.
- Mode change mid-frame (write) always restarts from count 0; no partial-frame events are produced.
- Inhibit = 1 prevents setting. A flag already set is cleared only by the write with bit6 = 1, by irq_ack, or by rst.
- Counter must never exceed STEP5. Count 0 is a valid non-event state.

Optional Feature:
FRAME_SEQ_IRQ_EN:
- Defined: frame_irq logic as described above.
- Undefined:
  - frame_irq is tied to constant 0; irq_ack and reg_data[6] are ignored.
  - No IRQ/inhibit registers are synthesized.
  - Pulse timing is identical.

Test Plan:
- Reset, no writes, run 14916 cycles:
  - qtr_clk pulses on cycles 3729, 7457, 11186, 14915.
  - hlf_clk pulses on cycles 7457 and 14915 only.
  - frame_irq rises at cycle 14915.
- Write 0x80 at cycle 100:
  - qtr_clk and hlf_clk pulse at cycle 101.
  - Next events occur 3729 and 7457 cycles after the write.
  - No pulse or IRQ at STEP4.
  - qtr + hlf pulse at write + 18641; frame_irq stays 0.
- Write 0x40, then run two full 4-step frames: frame_irq stays 0 throughout. Write 0x00, then run one frame: frame_irq = 1.
- With frame_irq = 1, pulse irq_ack: frame_irq = 0 the next cycle. Assert irq_ack on the exact cycle count == STEP4: frame_irq remains 1.
- Assert reg_wr = 0x00 on the cycle count == STEP2: no hlf/qtr pulse follows, and the counter restarts at 0.
- Assert rst mid-frame at count 9000: outputs go 0 and the counter goes 0. With FRAME_SEQ_IRQ_EN undefined, rerun the first scenario: identical pulses, frame_irq constant 0.

Source files
------------

// File: rtl/frame_sequencer.sv
// frame_sequencer: APU frame counter. It generates quarter-frame and half-frame
// clock pulses for the pulse channels in 4-step or 5-step mode, and a frame
// interrupt flag.
//
// Optional feature macro: FRAME_SEQ_IRQ_EN
//   defined   -> frame IRQ flag with inhibit bit and acknowledge
//   undefined -> frame_irq tied to 0; irq_ack and reg_data[6] are ignored
//
// Ports:
//   apu_clk   in   APU cycle clock
//   rst       in   synchronous active-high reset
//   reg_wr    in   frame-counter register write strobe
//   reg_data  in   [7] mode (1 = 5-step), [6] IRQ inhibit
//   irq_ack   in   frame IRQ acknowledge (status read)
//   qtr_clk   out  one-cycle quarter-frame pulse
//   hlf_clk   out  one-cycle half-frame pulse
//   frame_irq out  frame interrupt flag (level)
module frame_sequencer #(
  parameter int unsigned STEP1 = 3728,
  parameter int unsigned STEP2 = 7456,
  parameter int unsigned STEP3 = 11185,
  parameter int unsigned STEP4 = 14914,
  parameter int unsigned STEP5 = 18640,
  parameter int unsigned CNT_W = 15
) (
  input  logic       apu_clk,
  input  logic       rst,
  input  logic       reg_wr,
  input  logic [7:0] reg_data,
  input  logic       irq_ack,
  output logic       qtr_clk,
  output logic       hlf_clk,
  output logic       frame_irq
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             qtr_q, qtr_d;
  logic             hlf_q, hlf_d;
  logic             at_s1, at_s2, at_s3, at_s4, at_s5;
  logic             at_last, frame_end, irq_evt;

  // Step decode on the current count
  always_comb begin
    at_s1     = (cnt_q == CNT_W'(STEP1));
    at_s2     = (cnt_q == CNT_W'(STEP2));
    at_s3     = (cnt_q == CNT_W'(STEP3));
    at_s4     = (cnt_q == CNT_W'(STEP4));
    at_s5     = (cnt_q == CNT_W'(STEP5));
    at_last   = mode_q ? at_s5 : at_s4;
    // Inequality keeps the counter bounded even if it were ever past the last step
    frame_end = mode_q ? (cnt_q >= CNT_W'(STEP5)) : (cnt_q >= CNT_W'(STEP4));
    irq_evt   = !mode_q && at_s4;
  end

  // Counter, mode and pulse next-state; a write restarts the frame and masks the step
  always_comb begin
    cnt_d  = frame_end ? '0 : cnt_q + CNT_W'(1);
    mode_d = mode_q;
    qtr_d  = at_s1 | at_s2 | at_s3 | at_last;
    hlf_d  = at_s2 | at_last;
    if (reg_wr) begin
      cnt_d  = '0;
      mode_d = reg_data[7];
      qtr_d  = reg_data[7];
      hlf_d  = reg_data[7];
    end
  end

  always_ff @(posedge apu_clk) begin
    if (rst) begin
      cnt_q  <= '0;
      mode_q <= 1'b0;
      qtr_q  <= 1'b0;
      hlf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      qtr_q  <= qtr_d;
      hlf_q  <= hlf_d;
    end
  end

  assign qtr_clk = qtr_q;
  assign hlf_clk = hlf_q;

`ifdef FRAME_SEQ_IRQ_EN
  logic inh_q, inh_d;
  logic irq_q, irq_d;
  logic unused_c;

  // IRQ flag: set beats acknowledge; a write suppresses the step's set
  always_comb begin
    inh_d = inh_q;
    irq_d = irq_q;
    if (reg_wr) begin
      inh_d = reg_data[6];
      if (reg_data[6] || irq_ack) irq_d = 1'b0;
    end else if (irq_evt && !inh_q) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge apu_clk) begin
    if (rst) begin
      inh_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      inh_q <= inh_d;
      irq_q <= irq_d;
    end
  end

  assign frame_irq = irq_q;
  assign unused_c  = ^reg_data[5:0];
`else
  logic unused_c;

  assign frame_irq = 1'b0;
  assign unused_c  = ^{irq_evt, irq_ack, reg_data[6:0]};
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Testbench for frame_sequencer: directed frame scenarios with randomized
// acknowledge pulses and don't-care data bits, checked every cycle against a
// frame-phase model plus literal expectations at the documented cycles.
module tb_frame_sequencer;

  localparam int S1 = 3728;
  localparam int S2 = 7456;
  localparam int S3 = 11185;
  localparam int S4 = 14914;
  localparam int S5 = 18640;

`ifdef FRAME_SEQ_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       apu_clk = 1'b0;
  logic       rst = 1'b0;
  logic       reg_wr = 1'b0;
  logic [7:0] reg_data = 8'h00;
  logic       irq_ack = 1'b0;
  logic       qtr_clk, hlf_clk, frame_irq;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  frame_sequencer dut (
    .apu_clk  (apu_clk),
    .rst      (rst),
    .reg_wr   (reg_wr),
    .reg_data (reg_data),
    .irq_ack  (irq_ack),
    .qtr_clk  (qtr_clk),
    .hlf_clk  (hlf_clk),
    .frame_irq(frame_irq)
  );

  always #5 apu_clk = ~apu_clk;

  // Model: cycles elapsed since the last restart, reduced modulo the frame period
  int step_at [5] = '{S1, S2, S3, S4, S5};
  int elapsed = 0;
  bit m_mode = 1'b0;
  bit m_inh = 1'b0;
  bit m_irq = 1'b0;
  bit e_q = 1'b0;
  bit e_h = 1'b0;

  function automatic void frame_events(input bit md, input int ph,
                                       output bit q, output bit h, output bit irq);
    q = 1'b0; h = 1'b0; irq = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (ph == step_at[i]) begin
        if (!md && i < 4) begin
          q = 1'b1; h = (i == 1 || i == 3); irq = (i == 3);
        end
        if (md && i != 3) begin
          q = 1'b1; h = (i == 1 || i == 4);
        end
      end
    end
  endfunction

  always @(posedge apu_clk) begin
    bit q, h, s;
    int period;
    if (rst) begin
      elapsed = 0; m_mode = 1'b0; m_inh = 1'b0; m_irq = 1'b0;
      e_q = 1'b0; e_h = 1'b0;
    end else if (reg_wr) begin
      m_mode = reg_data[7]; m_inh = reg_data[6]; elapsed = 0;
      e_q = reg_data[7]; e_h = reg_data[7];
      if (reg_data[6] || irq_ack) m_irq = 1'b0;
    end else begin
      period = m_mode ? S5 + 1 : S4 + 1;
      frame_events(m_mode, elapsed % period, q, h, s);
      e_q = q; e_h = h;
      if (s && !m_inh) m_irq = 1'b1;
      else if (irq_ack) m_irq = 1'b0;
      elapsed++;
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge apu_clk) begin
    if (checking) begin
      check("qtr_clk", qtr_clk, e_q);
      check("hlf_clk", hlf_clk, e_h);
      check("frame_irq", frame_irq, IRQ_EN & m_irq);
    end
  end

  task automatic step(input bit r, input bit wr, input logic [7:0] d, input bit ack);
    rst = r; reg_wr = wr; reg_data = d; irq_ack = ack;
    @(posedge apu_clk);
    @(negedge apu_clk);
    rst = 1'b0; reg_wr = 1'b0; irq_ack = 1'b0;
  endtask

  function automatic bit rnd_ack();
    return ($urandom_range(0, 199) == 0);
  endfunction

  function automatic logic [7:0] rnd_low();
    return 8'($urandom_range(0, 63));
  endfunction

  initial begin
    // Reset, then run to count 9000 and reset mid-frame
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    checking = 1'b1;
    for (int k = 1; k <= 9000; k++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      if (k == 3729) check("pre_qtr_s1", qtr_clk, 1'b1);
      if (k == 7457) check("pre_hlf_s2", hlf_clk, 1'b1);
    end
    // rst overrides a simultaneous 5-step write and acknowledge
    step(1'b1, 1'b1, 8'hC0, 1'b1);
    check("rst_qtr", qtr_clk, 1'b0);
    check("rst_hlf", hlf_clk, 1'b0);
    check("rst_irq", frame_irq, 1'b0);

    // Full 4-step frame with no writes; ack lands on the STEP4 cycle
    for (int k = 1; k <= 14916; k++) begin
      step(1'b0, 1'b0, 8'h00, k == 14915);
      if (k == 3728)  check("a_qtr_idle", qtr_clk, 1'b0);
      if (k == 3729)  begin check("a_qtr_s1", qtr_clk, 1'b1); check("a_hlf_s1", hlf_clk, 1'b0); end
      if (k == 7457)  begin check("a_qtr_s2", qtr_clk, 1'b1); check("a_hlf_s2", hlf_clk, 1'b1); end
      if (k == 11186) begin check("a_qtr_s3", qtr_clk, 1'b1); check("a_hlf_s3", hlf_clk, 1'b0); end
      if (k == 14914) check("a_irq_before", frame_irq, 1'b0);
      if (k == 14915) begin
        check("a_qtr_s4", qtr_clk, 1'b1); check("a_hlf_s4", hlf_clk, 1'b1);
        check("a_irq_set_beats_ack", frame_irq, IRQ_EN);
      end
      if (k == 14916) check("a_qtr_after", qtr_clk, 1'b0);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("ack_clears", frame_irq, 1'b0);

    // 5-step mode write: immediate pulse, STEP4 silent, last step at write+18641
    for (int k = 0; k < 97; k++) step(1'b0, 1'b0, 8'h00, rnd_ack());
    step(1'b0, 1'b1, 8'h80 | rnd_low(), 1'b0);
    check("m5_imm_qtr", qtr_clk, 1'b1);
    check("m5_imm_hlf", hlf_clk, 1'b1);
    for (int k = 1; k <= 18641; k++) begin
      step(1'b0, 1'b0, 8'h00, rnd_ack());
      if (k == 1)     check("m5_imm_width", qtr_clk, 1'b0);
      if (k == 3729)  check("m5_qtr_s1", qtr_clk, 1'b1);
      if (k == 7457)  check("m5_hlf_s2", hlf_clk, 1'b1);
      if (k == 14915) begin check("m5_no_qtr_s4", qtr_clk, 1'b0); check("m5_no_irq_s4", frame_irq, 1'b0); end
      if (k == 18641) begin check("m5_qtr_s5", qtr_clk, 1'b1); check("m5_hlf_s5", hlf_clk, 1'b1); end
    end

    // Inhibited 4-step mode for two full frames
    step(1'b0, 1'b1, 8'h40 | rnd_low(), 1'b0);
    check("inh_no_imm", qtr_clk, 1'b0);
    for (int k = 1; k <= 2 * (S4 + 1); k++) begin
      step(1'b0, 1'b0, 8'h00, rnd_ack());
      if (k == S4 + 1 || k == 2 * (S4 + 1)) begin
        check("inh_qtr_s4", qtr_clk, 1'b1);
        check("inh_irq_low", frame_irq, 1'b0);
      end
    end

    // Write 0x00 on the STEP2 cycle: pulses suppressed, frame restarts
    for (int k = 0; k < S2; k++) step(1'b0, 1'b0, 8'h00, rnd_ack());
    step(1'b0, 1'b1, 8'h00 | rnd_low(), 1'b0);
    check("s2wr_qtr", qtr_clk, 1'b0);
    check("s2wr_hlf", hlf_clk, 1'b0);
    for (int k = 1; k <= S4 + 1; k++) begin
      step(1'b0, 1'b0, 8'h00, k == S4 + 1);
      if (k == 3728) check("s2wr_no_old_s3", qtr_clk, 1'b0);
      if (k == 3729) check("s2wr_restart_s1", qtr_clk, 1'b1);
      if (k == S4 + 1) check("uninh_irq_set", frame_irq, IRQ_EN);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("final_ack", frame_irq, 1'b0);

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
